fir_frame_arbiter: RTL and testbench



---
 rtl/fir_frame_arbiter.sv | 129 ++++++++++++
 tb/tb_fir_frame_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_frame_arbiter.sv
// Round-robin frame arbiter sharing one FIR filter between NREQ streams.
// Each frame is followed by NTAPS-1 zero samples so no history leaks into the next owner.
module fir_frame_arbiter #(
  parameter int NREQ   = 4,
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 16,
  parameter int NTAPS  = 11,
  parameter int FLW    = 8
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*IWIDTH-1:0]     req_data,
  input  logic [NREQ-1:0]            req_last,
  output logic [NREQ-1:0]            req_ready,
  output logic                       fir_valid,
  output logic [IWIDTH-1:0]          fir_din,
  input  logic                       fir_out_valid,
  input  logic [OWIDTH-1:0]          fir_dout,
  output logic                       res_valid,
  output logic [OWIDTH-1:0]          res_data,
  output logic [$clog2(NREQ)-1:0]    res_id,
  output logic                       res_last,
  output logic                       busy,
  output logic                       ovf,
  output logic [1:0]                 state_dbg
);

  localparam int IDW = $clog2(NREQ);
  // Wide enough for the largest expected result count, (2^FLW-1) + (NTAPS-1).
  localparam int CW  = $clog2(2**FLW + NTAPS);
  localparam int FCW = $clog2(NTAPS);
  localparam logic [CW-1:0]  FULL      = CW'(2**FLW - 1);
  localparam logic [FCW-1:0] FLUSH_END = FCW'(NTAPS - 2);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3} state_t;

  // Handshake: a sample moves when req_valid[i] and req_ready[i] are both high at a
  // rising clk edge; req_ready is only ever high for the current owner while in STREAM.
  state_t            state;
  logic [IDW-1:0]    grant, rr_ptr, nxt_grant;
  logic [CW-1:0]     in_cnt, out_cnt, exp_cnt, in_cnt_nxt;
  logic [FCW-1:0]    flush_cnt;
  logic              accept;
  logic [IWIDTH-1:0] sample;

  always_comb begin
    nxt_grant = rr_ptr;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) nxt_grant = IDW'((int'(rr_ptr) + k) % NREQ);
    end
  end

  assign accept     = (state == STREAM) && req_valid[grant];
  assign sample     = req_data[int'(grant)*IWIDTH +: IWIDTH];
  assign in_cnt_nxt = in_cnt + CW'(1);
  assign exp_cnt    = in_cnt + CW'(NTAPS - 1);
  assign req_ready  = (state == STREAM) ? (NREQ'(1) << grant) : '0;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (arst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= IDW'(NREQ - 1);
      in_cnt    <= '0;
      out_cnt   <= '0;
      flush_cnt <= '0;
      fir_valid <= 1'b0;
      fir_din   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_last  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      fir_valid <= 1'b0;
      fir_din   <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_data  <= fir_dout;
      res_id    <= grant;
      // Filter outputs are counted only while a frame is owned.
      if (fir_out_valid && state != IDLE) begin
        res_valid <= 1'b1;
        res_last  <= (out_cnt == exp_cnt - CW'(1));
        out_cnt   <= out_cnt + CW'(1);
      end
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant  <= nxt_grant;
            rr_ptr <= nxt_grant;
            state  <= STREAM;
          end
        end
        STREAM: begin
          flush_cnt <= '0;
          if (accept) begin
            fir_valid <= 1'b1;
            fir_din   <= sample;
            in_cnt    <= in_cnt_nxt;
            if (req_last[grant]) begin
              state <= FLUSH;
            end else if (in_cnt_nxt == FULL) begin
              ovf   <= 1'b1;
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          fir_valid <= 1'b1;
          flush_cnt <= flush_cnt + FCW'(1);
          if (flush_cnt == FLUSH_END) state <= DRAIN;
        end
        DRAIN: begin
          if (out_cnt == exp_cnt) begin
            state   <= IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_frame_arbiter.sv
// Directed bench for fir_frame_arbiter with a behavioural 11-tap filter (coef k+1, output >>4).
module tb_fir_frame_arbiter;

  localparam int NREQ = 4, IW = 16, OW = 16, NTAPS = 11, FLW = 3;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*IW-1:0] req_data = '0;
  logic [NREQ-1:0] req_last = '0;
  logic [NREQ-1:0] req_ready;
  logic            fir_valid;
  logic [IW-1:0]   fir_din;
  logic            fir_out_valid = 1'b0;
  logic [OW-1:0]   fir_dout = '0;
  logic            res_valid;
  logic [OW-1:0]   res_data;
  logic [1:0]      res_id;
  logic            res_last;
  logic            busy;
  logic            ovf;
  logic [1:0]      state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] fir_q[$];
  int          fir_cyc_q[$];
  logic [15:0] res_data_q[$];
  logic [1:0]  res_id_q[$];
  logic        res_last_q[$];

  fir_frame_arbiter #(.NREQ(NREQ), .IWIDTH(IW), .OWIDTH(OW), .NTAPS(NTAPS), .FLW(FLW)) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fir_valid(fir_valid), .fir_din(fir_din),
    .fir_out_valid(fir_out_valid), .fir_dout(fir_dout),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_last(res_last),
    .busy(busy), .ovf(ovf), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural filter: 1-cycle latency, coefficient k+1 on delay tap k
  logic [15:0] dl [0:NTAPS-1] = '{default: '0};
  logic [31:0] acc;
  always @(posedge clk) begin
    fir_out_valid <= 1'b0;
    if (fir_valid) begin
      acc = 32'(fir_din);
      for (int j = 1; j < NTAPS; j++) acc = acc + 32'(j + 1) * 32'(dl[j-1]);
      for (int j = NTAPS - 1; j > 0; j--) dl[j] <= dl[j-1];
      dl[0] <= fir_din;
      fir_out_valid <= 1'b1;
      fir_dout <= acc[19:4];
    end
  end

  // monitor
  always @(negedge clk) begin
    cyc++;
    if (fir_valid) begin
      fir_q.push_back(fir_din);
      fir_cyc_q.push_back(cyc);
    end
    if (res_valid) begin
      res_data_q.push_back(res_data);
      res_id_q.push_back(res_id);
      res_last_q.push_back(res_last);
    end
  end

  // driver tasks
  task automatic clear_q();
    fir_q.delete(); fir_cyc_q.delete();
    res_data_q.delete(); res_id_q.delete(); res_last_q.delete();
  endtask

  task automatic drive_sample(input int id, input logic [15:0] d, input logic l);
    int t;
    req_valid[id] = 1'b1;
    req_data[id*IW +: IW] = d;
    req_last[id] = l;
    t = 0;
    while (req_ready[id] !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      n_cmp++; n_err++;
      $display("FAIL drive_timeout req%0d: ready=%b required=1", id, req_ready[id]);
    end
    @(negedge clk);
    req_valid[id] = 1'b0;
    req_last[id] = 1'b0;
  endtask

  task automatic send_frame(input int id, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) drive_sample(id, base + 16'(i), (i == n - 1));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 400) begin
      n_err++;
      $display("FAIL idle_timeout: busy=%b required=0", busy);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    arst = 1'b1;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    arst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({state_dbg, busy, ovf, fir_valid, res_valid, res_last} !== 7'b0 ||
        req_ready !== 4'b0 || fir_din !== 16'h0 || res_data !== 16'h0 || res_id !== 2'b0) begin
      n_err++;
      $display("FAIL reset_outputs: state=%0d busy=%b ovf=%b fv=%b rv=%b rl=%b rdy=%b din=%h rd=%h rid=%0d required all 0",
               state_dbg, busy, ovf, fir_valid, res_valid, res_last, req_ready, fir_din, res_data, res_id);
    end
    arst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [15:0] e;
    clear_q();
    send_frame(0, 3, 16'd5);
    wait_idle();
    n_cmp++;
    if (fir_q.size() != 13) begin
      n_err++; $display("FAIL single_fir_count: got %0d required 13", fir_q.size());
    end
    for (int i = 0; i < fir_q.size(); i++) begin
      e = (i < 3) ? 16'(5 + i) : 16'h0;
      n_cmp++;
      if (fir_q[i] !== e) begin
        n_err++; $display("FAIL single_fir_din[%0d]: got %h required %h", i, fir_q[i], e);
      end
    end
    if (fir_cyc_q.size() == 13) begin
      n_cmp++;
      if (fir_cyc_q[12] - fir_cyc_q[0] != 12) begin
        n_err++; $display("FAIL single_fir_span: got %0d required 12", fir_cyc_q[12] - fir_cyc_q[0]);
      end
    end
    n_cmp++;
    if (res_id_q.size() != 13) begin
      n_err++; $display("FAIL single_res_count: got %0d required 13", res_id_q.size());
    end
    for (int i = 0; i < res_id_q.size(); i++) begin
      n_cmp++;
      if (res_id_q[i] !== 2'd0 || res_last_q[i] !== (i == 12)) begin
        n_err++; $display("FAIL single_res[%0d]: id=%0d last=%b required id=0 last=%b", i, res_id_q[i], res_last_q[i], (i == 12));
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 4'b0) begin
      n_err++; $display("FAIL single_end: busy=%b ready=%b required 0 0000", busy, req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] order2 [3];
    logic [1:0] e_id;
    order2 = '{2'd0, 2'd1, 2'd2};
    reset_dut();
    clear_q();
    fork
      send_frame(0, 2, 16'h10);
      send_frame(2, 2, 16'h20);
    join
    wait_idle();
    n_cmp++;
    if (res_id_q.size() != 24) begin
      n_err++; $display("FAIL rr1_res_count: got %0d required 24", res_id_q.size());
    end
    for (int i = 0; i < res_id_q.size(); i++) begin
      e_id = (i < 12) ? 2'd0 : 2'd2;
      n_cmp++;
      if (res_id_q[i] !== e_id || res_last_q[i] !== (i % 12 == 11)) begin
        n_err++; $display("FAIL rr1_res[%0d]: id=%0d last=%b required id=%0d last=%b", i, res_id_q[i], res_last_q[i], e_id, (i % 12 == 11));
      end
    end
    if (fir_q.size() > 12) begin
      n_cmp++;
      if (fir_q[12] !== 16'h20) begin
        n_err++; $display("FAIL rr1_second_owner_din: got %h required 0020", fir_q[12]);
      end
    end
    clear_q();
    fork
      send_frame(0, 2, 16'h30);
      send_frame(1, 2, 16'h40);
      send_frame(2, 2, 16'h50);
    join
    wait_idle();
    n_cmp++;
    if (res_id_q.size() != 36) begin
      n_err++; $display("FAIL rr2_res_count: got %0d required 36", res_id_q.size());
    end
    for (int i = 0; i < res_id_q.size() && i < 36; i++) begin
      e_id = order2[i / 12];
      n_cmp++;
      if (res_id_q[i] !== e_id || res_last_q[i] !== (i % 12 == 11)) begin
        n_err++; $display("FAIL rr2_res[%0d]: id=%0d last=%b required id=%0d last=%b", i, res_id_q[i], res_last_q[i], e_id, (i % 12 == 11));
      end
    end
  endtask

  task automatic test_stall();
    clear_q();
    drive_sample(1, 16'h61, 1'b0);
    drive_sample(1, 16'h62, 1'b0);
    repeat (3) @(negedge clk);
    drive_sample(1, 16'h63, 1'b0);
    drive_sample(1, 16'h64, 1'b1);
    wait_idle();
    n_cmp++;
    if (fir_q.size() != 14) begin
      n_err++; $display("FAIL stall_fir_count: got %0d required 14", fir_q.size());
    end
    if (fir_q.size() >= 3) begin
      n_cmp++;
      if (fir_cyc_q[2] - fir_cyc_q[1] != 4 || fir_cyc_q[1] - fir_cyc_q[0] != 1 || fir_q[2] !== 16'h63) begin
        n_err++; $display("FAIL stall_gap: gaps %0d,%0d din=%h required 1,4 0063",
                          fir_cyc_q[1] - fir_cyc_q[0], fir_cyc_q[2] - fir_cyc_q[1], fir_q[2]);
      end
    end
    n_cmp++;
    if (res_id_q.size() != 14) begin
      n_err++; $display("FAIL stall_res_count: got %0d required 14", res_id_q.size());
    end
    for (int i = 0; i < res_id_q.size(); i++) begin
      n_cmp++;
      if (res_id_q[i] !== 2'd1 || res_last_q[i] !== (i == 13)) begin
        n_err++; $display("FAIL stall_res[%0d]: id=%0d last=%b required id=1 last=%b", i, res_id_q[i], res_last_q[i], (i == 13));
      end
    end
  endtask

  task automatic test_overflow();
    clear_q();
    for (int i = 0; i < 7; i++) drive_sample(3, 16'(i + 1), 1'b0);
    n_cmp++;
    if (ovf !== 1'b1 || req_ready[3] !== 1'b0 || state_dbg !== 2'd2) begin
      n_err++; $display("FAIL ovf_cut: ovf=%b ready3=%b state=%0d required 1 0 2", ovf, req_ready[3], state_dbg);
    end
    drive_sample(3, 16'd8, 1'b0);
    drive_sample(3, 16'd9, 1'b0);
    drive_sample(3, 16'd10, 1'b1);
    wait_idle();
    n_cmp++;
    if (fir_q.size() != 30) begin
      n_err++; $display("FAIL ovf_fir_count: got %0d required 30", fir_q.size());
    end
    if (fir_q.size() == 30) begin
      n_cmp++;
      if (fir_q[6] !== 16'd7 || fir_q[7] !== 16'd0 || fir_q[16] !== 16'd0 || fir_q[17] !== 16'd8) begin
        n_err++; $display("FAIL ovf_fir_din: [6]=%h [7]=%h [16]=%h [17]=%h required 7 0 0 8", fir_q[6], fir_q[7], fir_q[16], fir_q[17]);
      end
    end
    n_cmp++;
    if (res_id_q.size() != 30) begin
      n_err++; $display("FAIL ovf_res_count: got %0d required 30", res_id_q.size());
    end
    for (int i = 0; i < res_id_q.size(); i++) begin
      n_cmp++;
      if (res_id_q[i] !== 2'd3 || res_last_q[i] !== (i == 16 || i == 29)) begin
        n_err++; $display("FAIL ovf_res[%0d]: id=%0d last=%b required id=3 last=%b", i, res_id_q[i], res_last_q[i], (i == 16 || i == 29));
      end
    end
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky: got %b required 1", ovf);
    end
  endtask

  task automatic test_reset_mid_flush();
    clear_q();
    drive_sample(2, 16'd9, 1'b0);
    drive_sample(2, 16'd10, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'd2) begin
      n_err++; $display("FAIL rst_pre_state: got %0d required 2", state_dbg);
    end
    arst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({state_dbg, busy, ovf, fir_valid, res_valid, res_last} !== 7'b0 ||
        req_ready !== 4'b0 || fir_din !== 16'h0 || res_data !== 16'h0 || res_id !== 2'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: state=%0d busy=%b ovf=%b fv=%b rv=%b rl=%b rdy=%b din=%h rd=%h rid=%0d required all 0",
               state_dbg, busy, ovf, fir_valid, res_valid, res_last, req_ready, fir_din, res_data, res_id);
    end
    arst = 1'b0;
    repeat (4) @(negedge clk);
    clear_q();
    send_frame(1, 1, 16'd3);
    wait_idle();
    n_cmp++;
    if (res_id_q.size() != 11) begin
      n_err++; $display("FAIL rst_next_count: got %0d required 11", res_id_q.size());
    end
    for (int i = 0; i < res_id_q.size(); i++) begin
      n_cmp++;
      if (res_id_q[i] !== 2'd1 || res_last_q[i] !== (i == 10)) begin
        n_err++; $display("FAIL rst_next_res[%0d]: id=%0d last=%b required id=1 last=%b", i, res_id_q[i], res_last_q[i], (i == 10));
      end
    end
  endtask

  task automatic test_isolation();
    logic [15:0] e;
    clear_q();
    send_frame(0, 1, 16'h4000);
    wait_idle();
    n_cmp++;
    if (res_data_q.size() != 11) begin
      n_err++; $display("FAIL impulse_count: got %0d required 11", res_data_q.size());
    end
    for (int i = 0; i < res_data_q.size(); i++) begin
      e = 16'(16'h0400 * (i + 1));
      n_cmp++;
      if (res_data_q[i] !== e || res_id_q[i] !== 2'd0) begin
        n_err++; $display("FAIL impulse_res[%0d]: data=%h id=%0d required %h 0", i, res_data_q[i], res_id_q[i], e);
      end
    end
    clear_q();
    send_frame(1, 1, 16'h0000);
    wait_idle();
    n_cmp++;
    if (res_data_q.size() != 11) begin
      n_err++; $display("FAIL iso_count: got %0d required 11", res_data_q.size());
    end
    for (int i = 0; i < res_data_q.size(); i++) begin
      n_cmp++;
      if (res_data_q[i] !== 16'h0 || res_id_q[i] !== 2'd1 || res_last_q[i] !== (i == 10)) begin
        n_err++; $display("FAIL iso_res[%0d]: data=%h id=%0d last=%b required 0000 1 %b", i, res_data_q[i], res_id_q[i], res_last_q[i], (i == 10));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_stall();
    test_overflow();
    test_reset_mid_flush();
    test_isolation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
